// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants and fetch state encoding
package cpu_pkg;
   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;
   localparam logic [PC_W-1:0] PC_INC      = 16'd2;
   localparam logic [3:0]      OPC_HLT_DEF = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DROP   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush > stall > load priority
module if_id_reg
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic               stall_i,
   input  logic               load_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic               valid_o,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instr_o
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         pc_o    <= '0;
         instr_o <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (!stall_i) begin
         valid_o <= load_i;
         if (load_i) begin
            pc_o    <= pc_i;
            instr_o <= instr_i;
         end
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, hold buffer, redirect, halt
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter logic [3:0]      OPC_HLT  = OPC_HLT_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_rdy,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               if_id_valid,
   output logic [PC_W-1:0]    if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [PC_W-1:0]    pc,
   output logic               hlt
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        perf_fetch_cnt,
   output logic [15:0]        perf_stall_cnt
`endif
);
   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
   logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
   logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
   logic               ld;
   logic [PC_W-1:0]    ld_pc;
   logic [INSTR_W-1:0] ld_instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         pend_pc_q   <= '0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_pc_q   <= pend_pc_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_pc_d   = pend_pc_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      ld          = 1'b0;
      ld_pc       = pc_q + PC_INC;
      ld_instr    = imem_data;
      unique case (state_q)
         ST_FETCH: begin
            if (flush_i) begin
               // A request still in flight must complete before the redirect takes effect.
               if (imem_rdy) pc_d = redirect_pc_i;
               else begin
                  pend_pc_d = redirect_pc_i;
                  state_d   = ST_DROP;
               end
            end else if (imem_rdy) begin
               if (stall_i) begin
                  buf_pc_d    = pc_q;
                  buf_instr_d = imem_data;
                  state_d     = ST_HOLD;
               end else begin
                  ld   = 1'b1;
                  pc_d = pc_q + PC_INC;
                  if (imem_data[15:12] == OPC_HLT) state_d = ST_HALTED;
               end
            end
         end
         ST_DROP: begin
            if (flush_i) pend_pc_d = redirect_pc_i;
            if (imem_rdy) begin
               pc_d    = flush_i ? redirect_pc_i : pend_pc_q;
               state_d = ST_FETCH;
            end
         end
         ST_HOLD: begin
            ld_pc    = buf_pc_q + PC_INC;
            ld_instr = buf_instr_q;
            if (flush_i) begin
               pc_d    = redirect_pc_i;
               state_d = ST_FETCH;
            end else if (!stall_i) begin
               ld      = 1'b1;
               pc_d    = buf_pc_q + PC_INC;
               state_d = (buf_instr_q[15:12] == OPC_HLT) ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (flush_i) begin
               pc_d    = redirect_pc_i;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   if_id_reg u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .stall_i (stall_i),
      .load_i  (ld),
      .pc_i    (ld_pc),
      .instr_i (ld_instr),
      .valid_o (if_id_valid),
      .pc_o    (if_id_pc),
      .instr_o (if_id_instr)
   );

   assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign hlt       = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
   logic stall_cyc;
   assign stall_cyc = (state_q == ST_HOLD) || ((state_q == ST_FETCH) && !imem_rdy);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (ld && perf_fetch_cnt != 16'hFFFF) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
         if (stall_cyc && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic        stall_i;
   logic        flush_i;
   logic [15:0] redirect_pc_i;
   logic        if_id_valid;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_instr;
   logic [15:0] pc;
   logic        hlt;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   logic [15:0] mem [0:255];
   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[8:1]];

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdy      (imem_rdy),
      .imem_data     (imem_data),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .redirect_pc_i (redirect_pc_i),
      .if_id_valid   (if_id_valid),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .pc            (pc),
      .hlt           (hlt)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'h1234;
      mem[8'h01] = 16'h2345;
      mem[8'h02] = 16'h3456;
      mem[8'h03] = 16'h4567;
      mem[8'h08] = 16'hF000;
      mem[8'h20] = 16'h5678;
      mem[8'hFF] = 16'h1111;
      rst_n = 1'b0; imem_rdy = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 16'h0000;

      #2;
      chk("rst_req", imem_req, 16'd1);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", if_id_valid, 16'd0);
      chk("rst_ifpc", if_id_pc, 16'h0000);
      chk("rst_instr", if_id_instr, 16'h0000);
      chk("rst_hlt", hlt, 16'd0);
      #10 rst_n = 1'b1;

      // zero-wait streaming
      step();
      chk("s0_addr", imem_addr, 16'h0002);
      chk("s0_valid", if_id_valid, 16'd1);
      chk("s0_ifpc", if_id_pc, 16'h0002);
      chk("s0_instr", if_id_instr, 16'h1234);
      step();
      chk("s1_addr", imem_addr, 16'h0004);
      chk("s1_ifpc", if_id_pc, 16'h0004);
      chk("s1_instr", if_id_instr, 16'h2345);

      // stall two cycles while data for 0x0004 returns
      stall_i = 1'b1;
      step();
      chk("h0_req", imem_req, 16'd0);
      chk("h0_valid", if_id_valid, 16'd1);
      chk("h0_ifpc", if_id_pc, 16'h0004);
      chk("h0_instr", if_id_instr, 16'h2345);
      step();
      chk("h1_req", imem_req, 16'd0);
      chk("h1_ifpc", if_id_pc, 16'h0004);
      stall_i = 1'b0;
      step();
      chk("hr_valid", if_id_valid, 16'd1);
      chk("hr_ifpc", if_id_pc, 16'h0006);
      chk("hr_instr", if_id_instr, 16'h3456);
      chk("hr_addr", imem_addr, 16'h0006);
      chk("hr_req", imem_req, 16'd1);

      // three-cycle memory wait
      imem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("w_valid", if_id_valid, 16'd0);
         chk("w_addr", imem_addr, 16'h0006);
      end
      imem_rdy = 1'b1;
      step();
      chk("wd_valid", if_id_valid, 16'd1);
      chk("wd_instr", if_id_instr, 16'h4567);
      chk("wd_ifpc", if_id_pc, 16'h0008);

      // flush while request to 0x0008 is pending
      imem_rdy = 1'b0; flush_i = 1'b1; redirect_pc_i = 16'h0040;
      step();
      chk("d0_valid", if_id_valid, 16'd0);
      chk("d0_addr", imem_addr, 16'h0008);
      chk("d0_req", imem_req, 16'd1);
      flush_i = 1'b0;
      step();
      chk("d1_addr", imem_addr, 16'h0008);
      imem_rdy = 1'b1;
      step();
      chk("d2_addr", imem_addr, 16'h0040);
      chk("d2_valid", if_id_valid, 16'd0);
      step();
      chk("d3_valid", if_id_valid, 16'd1);
      chk("d3_ifpc", if_id_pc, 16'h0042);
      chk("d3_instr", if_id_instr, 16'h5678);

      // halt at 0x0010, then release with a redirect
      flush_i = 1'b1; redirect_pc_i = 16'h0010;
      step();
      chk("f_addr", imem_addr, 16'h0010);
      chk("f_valid", if_id_valid, 16'd0);
      flush_i = 1'b0;
      step();
      chk("t0_valid", if_id_valid, 16'd1);
      chk("t0_instr", if_id_instr, 16'hF000);
      chk("t0_ifpc", if_id_pc, 16'h0012);
      chk("t0_hlt", hlt, 16'd1);
      chk("t0_req", imem_req, 16'd0);
      step();
      chk("t1_hlt", hlt, 16'd1);
      chk("t1_valid", if_id_valid, 16'd0);
      chk("t1_req", imem_req, 16'd0);
      flush_i = 1'b1; redirect_pc_i = 16'h0020;
      step();
      chk("t2_hlt", hlt, 16'd0);
      chk("t2_addr", imem_addr, 16'h0020);
      chk("t2_req", imem_req, 16'd1);

      // top-of-memory: flush beats stall and rdy; then wrap
      redirect_pc_i = 16'hFFFE;
      step();
      chk("x0_addr", imem_addr, 16'hFFFE);
      stall_i = 1'b1; redirect_pc_i = 16'h0030;
      step();
      chk("x1_valid", if_id_valid, 16'd0);
      chk("x1_addr", imem_addr, 16'h0030);
      chk("x1_req", imem_req, 16'd1);
      stall_i = 1'b0; redirect_pc_i = 16'hFFFE;
      step();
      chk("x2_addr", imem_addr, 16'hFFFE);
      flush_i = 1'b0;
      step();
      chk("x3_valid", if_id_valid, 16'd1);
      chk("x3_ifpc", if_id_pc, 16'h0000);
      chk("x3_instr", if_id_instr, 16'h1111);
      chk("x3_addr", imem_addr, 16'h0000);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
